// File: rtl/dcache_pkg.sv
// dcache_pkg: geometry, FSM states and address-field split shared by the data cache.
package dcache_pkg;
  localparam int LINES = 32;
  localparam int WORDS_PER_LINE = 4;
  localparam int ADDR_W = 32;
  localparam int OFFSET_W = $clog2(WORDS_PER_LINE);
  localparam int INDEX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - 2 - OFFSET_W - INDEX_W;
  typedef enum logic [1:0] {IDLE = 2'd0, REFILL = 2'd1, WRITE = 2'd2} state_t;
  typedef logic [WORDS_PER_LINE-1:0][31:0] line_t;
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [INDEX_W-1:0] index;
    logic [OFFSET_W-1:0] offset;
  } addr_fields_t;
  // Takes the word address (byte offset already dropped).
  function automatic addr_fields_t split_addr(input logic [ADDR_W-3:0] a);
    return a;
  endfunction
endpackage

// File: rtl/dcache_array.sv
// dcache_array: flop-based tag/valid/data storage; valid bits clear on rst, tag/data are never reset.
module dcache_array import dcache_pkg::*; (
  input  logic                clk,
  input  logic                rst,
  input  logic [INDEX_W-1:0]  index,
  output logic                valid,
  output logic [TAG_W-1:0]    tag,
  output line_t               line,
  input  logic                line_we,
  input  logic [TAG_W-1:0]    line_tag,
  input  line_t               line_data,
  input  logic                word_we,
  input  logic [OFFSET_W-1:0] word_off,
  input  logic [31:0]         word_data
);
  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q [LINES];
  line_t data_q [LINES];
  assign valid = valid_q[index];
  assign tag = tag_q[index];
  assign line = data_q[index];
  always_ff @(posedge clk)
    if (rst) valid_q <= '0;
    else if (line_we) valid_q[index] <= 1'b1;
  always_ff @(posedge clk)
    if (line_we) begin
      data_q[index] <= line_data;
      tag_q[index] <= line_tag;
    end else if (word_we) begin
      data_q[index][word_off] <= word_data;
    end
endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped write-through no-write-allocate data cache controller.
// Define DCACHE_PERF_EN to add hit_cnt/miss_cnt performance counters.
module dcache_ctrl import dcache_pkg::*; (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        mem_read,
  input  logic                        mem_write,
  input  logic [ADDR_W-1:0]           addr,
  input  logic [31:0]                 wdata,
  output logic [31:0]                 rdata,
  output logic                        stall,
  output logic                        mm_req,
  output logic                        mm_we,
  output logic [ADDR_W-1:0]           mm_addr,
  output logic [31:0]                 mm_wdata,
  input  logic                        mm_ready,
  input  logic [32*WORDS_PER_LINE-1:0] mm_rdata
`ifdef DCACHE_PERF_EN
  ,
  output logic [31:0]                 hit_cnt,
  output logic [31:0]                 miss_cnt
`endif
);
  state_t state, next;
  addr_fields_t f;
  logic valid, hit, line_we, word_we;
  logic [TAG_W-1:0] tag;
  line_t line;
  assign f = split_addr(addr[ADDR_W-1:2]);
  assign hit = valid && tag == f.tag;
  dcache_array u_array (
    .clk(clk), .rst(rst), .index(f.index), .valid(valid), .tag(tag), .line(line),
    .line_we(line_we), .line_tag(f.tag), .line_data(mm_rdata),
    .word_we(word_we), .word_off(f.offset), .word_data(wdata)
  );
  always_ff @(posedge clk) state <= rst ? IDLE : next;
  always_comb begin
    next = state;
    stall = 1'b0;
    rdata = '0;
    mm_req = 1'b0;
    mm_we = 1'b0;
    mm_addr = '0;
    mm_wdata = '0;
    line_we = 1'b0;
    word_we = 1'b0;
    case (state)
      IDLE: begin
        stall = mem_write || (mem_read && !hit);
        rdata = (!mem_write && mem_read && hit) ? line[f.offset] : '0;
        next = mem_write ? WRITE : (mem_read && !hit) ? REFILL : IDLE;
      end
      REFILL: begin
        mm_req = 1'b1;
        mm_addr = {addr[ADDR_W-1:OFFSET_W+2], {(OFFSET_W+2){1'b0}}};
        stall = 1'b1;
        line_we = mm_ready;
        next = mm_ready ? IDLE : REFILL;
      end
      WRITE: begin
        mm_req = 1'b1;
        mm_we = 1'b1;
        mm_addr = addr;
        mm_wdata = wdata;
        stall = !mm_ready;
        word_we = mm_ready && hit;
        next = mm_ready ? IDLE : WRITE;
      end
      default: next = IDLE;
    endcase
  end
`ifdef DCACHE_PERF_EN
  // The hit that completes a refilled load is not counted as a hit.
  logic from_refill;
  always_ff @(posedge clk)
    if (rst) begin
      hit_cnt <= '0;
      miss_cnt <= '0;
      from_refill <= 1'b0;
    end else begin
      from_refill <= state == REFILL && mm_ready;
      if (state == IDLE && mem_read && !mem_write && hit && !from_refill) hit_cnt <= hit_cnt + 32'd1;
      if (state == IDLE && next == REFILL) miss_cnt <= miss_cnt + 32'd1;
    end
`endif
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: directed and randomized checks of dcache_ctrl against a line-level cache/memory model.
module tb_dcache_ctrl;
  logic clk = 0, rst = 1, mem_read = 0, mem_write = 0, mm_ready = 0;
  logic [31:0] addr = 0, wdata = 0, rdata, mm_addr, mm_wdata;
  logic stall, mm_req, mm_we;
  logic [127:0] mm_rdata = 0;
`ifdef DCACHE_PERF_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif
  int total = 0, bad = 0, hitc = 0, missc = 0;
  bit mv [32];
  logic [22:0] mt [32];
  logic [31:0] md [32][4];
  logic [31:0] mem [logic [31:0]];

  dcache_ctrl dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .addr(addr), .wdata(wdata),
    .rdata(rdata), .stall(stall), .mm_req(mm_req), .mm_we(mm_we), .mm_addr(mm_addr),
    .mm_wdata(mm_wdata), .mm_ready(mm_ready), .mm_rdata(mm_rdata)
`ifdef DCACHE_PERF_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );
  always #5 clk = ~clk;

  function automatic logic [31:0] mrd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : (a * 32'h0101_0101) ^ 32'h5A5A_5A5A;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 32; i++) mv[i] = 0;
    hitc = 0;
    missc = 0;
  endtask

  task automatic access(input bit w, input logic [31:0] a, input logic [31:0] d, input int lat,
                        output int scyc, output logic [31:0] rd);
    int idx, off, cyc, reqc, exp_s;
    logic [22:0] tg;
    logic [31:0] base;
    bit hit_e, done;
    idx = int'((a >> 4) & 32'd31);
    off = int'((a >> 2) & 32'd3);
    tg = a[31:9];
    base = a & ~32'hF;
    hit_e = mv[idx] && mt[idx] == tg;
    scyc = 0; reqc = 0; cyc = 0; done = 0; rd = 0;
    @(negedge clk);
    mem_read = !w; mem_write = w; addr = a; wdata = d;
    while (!done && cyc < 100) begin
      mm_ready = mm_req && (reqc + 1 == lat);
      if (mm_req) begin
        reqc++;
        mm_rdata = {mrd(base + 12), mrd(base + 8), mrd(base + 4), mrd(base)};
        total++;
        if (mm_we !== w || mm_addr !== (w ? a : base) || (w && mm_wdata !== d)) begin
          bad++;
          $display("FAIL mm_bus a=%h: we=%b addr=%h wdata=%h, want we=%b addr=%h wdata=%h",
                   a, mm_we, mm_addr, mm_wdata, w, w ? a : base, d);
        end
      end
      #1;
      if (stall) begin
        scyc++;
        total++;
        if (rdata !== 0) begin bad++; $display("FAIL rdata_while_stalled a=%h: got %h want 0", a, rdata); end
      end else begin
        done = 1;
        rd = rdata;
      end
      cyc++;
      if (!done) @(negedge clk);
    end
    total++;
    if (!done) begin bad++; $display("FAIL timeout a=%h: no completion in 100 cycles", a); end
    if (w) begin
      mem[a] = d;
      if (hit_e) md[idx][off] = d;
      exp_s = lat;
    end else if (hit_e) begin
      hitc++;
      exp_s = 0;
    end else begin
      for (int k = 0; k < 4; k++) md[idx][k] = mrd(base + 32'(4 * k));
      mv[idx] = 1; mt[idx] = tg;
      missc++;
      exp_s = lat + 1;
    end
    total++;
    if (scyc != exp_s) begin bad++; $display("FAIL stall_cycles a=%h w=%b: got %0d want %0d", a, w, scyc, exp_s); end
    total++;
    if (reqc != ((!w && hit_e) ? 0 : lat)) begin
      bad++; $display("FAIL mm_req_cycles a=%h: got %0d want %0d", a, reqc, (!w && hit_e) ? 0 : lat);
    end
    if (!w) begin
      total++;
      if (rd !== md[idx][off]) begin bad++; $display("FAIL load_data a=%h: got %h want %h", a, rd, md[idx][off]); end
    end
`ifdef DCACHE_PERF_EN
    @(negedge clk);
    mem_read = 0; mem_write = 0; mm_ready = 0;
    #1;
    total++;
    if (hit_cnt !== 32'(hitc) || miss_cnt !== 32'(missc)) begin
      bad++; $display("FAIL perf_cnt: got hit=%0d miss=%0d want hit=%0d miss=%0d", hit_cnt, miss_cnt, hitc, missc);
    end
`endif
  endtask

  task automatic go_idle();
    @(negedge clk);
    mem_read = 0; mem_write = 0; mm_ready = 0;
    #1;
    total++;
    if (stall !== 0 || mm_req !== 0 || rdata !== 0) begin
      bad++; $display("FAIL idle_outputs: stall=%b mm_req=%b rdata=%h, want 0 0 0", stall, mm_req, rdata);
    end
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    #1;
    clear_model();
    total++;
    if (stall !== 0 || mm_req !== 0 || mm_we !== 0 || mm_addr !== 0 || mm_wdata !== 0 || rdata !== 0) begin
      bad++;
      $display("FAIL reset_outputs: stall=%b req=%b we=%b addr=%h wdata=%h rdata=%h, want all 0",
               stall, mm_req, mm_we, mm_addr, mm_wdata, rdata);
    end
`ifdef DCACHE_PERF_EN
    total++;
    if (hit_cnt !== 0 || miss_cnt !== 0) begin bad++; $display("FAIL reset_cnt: hit=%0d miss=%0d want 0 0", hit_cnt, miss_cnt); end
`endif
  endtask

  task automatic test_read_miss();
    int s; logic [31:0] r;
    mem[32'h40] = 32'h11; mem[32'h44] = 32'h22; mem[32'h48] = 32'h33; mem[32'h4C] = 32'h44;
    access(0, 32'h40, 0, 3, s, r);
    total++;
    if (r !== 32'h11 || s != 4) begin bad++; $display("FAIL read_miss_0x40: rdata=%h stall=%0d want 11 4", r, s); end
  endtask

  task automatic test_read_hit();
    int s; logic [31:0] r;
    access(0, 32'h48, 0, 1, s, r);
    total++;
    if (r !== 32'h33 || s != 0) begin bad++; $display("FAIL read_hit_0x48: rdata=%h stall=%0d want 33 0", r, s); end
  endtask

  task automatic test_store_hit();
    int s; logic [31:0] r;
    access(1, 32'h44, 32'hDEADBEEF, 2, s, r);
    access(0, 32'h44, 0, 1, s, r);
    total++;
    if (r !== 32'hDEADBEEF || s != 0) begin bad++; $display("FAIL store_hit_reread: rdata=%h stall=%0d want deadbeef 0", r, s); end
  endtask

  task automatic test_store_miss();
    int s; logic [31:0] r;
    access(1, 32'h1000_0000, 32'hCAFE_F00D, 3, s, r);
    access(0, 32'h1000_0000, 0, 2, s, r);
    total++;
    if (r !== 32'hCAFE_F00D || s != 3) begin bad++; $display("FAIL store_miss_reread: rdata=%h stall=%0d want cafef00d 3", r, s); end
  endtask

  task automatic test_conflict();
    int s; logic [31:0] r;
    access(0, 32'h040, 0, 1, s, r);
    access(0, 32'h240, 0, 2, s, r);
    access(0, 32'h040, 0, 2, s, r);
    total++;
    if (r !== 32'h11 || s != 3) begin bad++; $display("FAIL conflict_reread: rdata=%h stall=%0d want 11 3", r, s); end
  endtask

  task automatic test_reset_mid_refill();
    int s; logic [31:0] r;
    access(0, 32'h1C0, 0, 1, s, r);
    @(negedge clk);
    mem_read = 1; mem_write = 0; addr = 32'h340; mm_ready = 0;
    @(negedge clk);
    #1;
    total++;
    if (mm_req !== 1) begin bad++; $display("FAIL refill_started: mm_req=%b want 1", mm_req); end
    @(negedge clk);
    rst = 1; mem_read = 0;
    @(negedge clk);
    rst = 0;
    #1;
    clear_model();
    total++;
    if (mm_req !== 0 || stall !== 0) begin bad++; $display("FAIL reset_mid_refill: mm_req=%b stall=%b want 0 0", mm_req, stall); end
    @(negedge clk);
    mm_ready = 1;
    mm_rdata = {4{32'hBAD0_BAD0}};
    #1;
    total++;
    if (mm_req !== 0 || stall !== 0) begin bad++; $display("FAIL stray_ready: mm_req=%b stall=%b want 0 0", mm_req, stall); end
    go_idle();
    access(0, 32'h40, 0, 2, s, r);
    total++;
    if (r !== 32'h11 || s != 3) begin bad++; $display("FAIL reread_after_reset: rdata=%h stall=%0d want 11 3", r, s); end
  endtask

  task automatic test_random();
    int s; logic [31:0] r, a;
    for (int i = 0; i < 60; i++) begin
      a = ($urandom_range(0, 3) << 9) | ($urandom_range(0, 3) << 4) | ($urandom_range(0, 3) << 2);
      access($urandom_range(0, 9) < 3, a, $urandom, $urandom_range(1, 4), s, r);
      if ($urandom_range(0, 3) == 0) go_idle();
    end
  endtask

  initial begin
    test_reset();
    test_read_miss();
    test_read_hit();
    test_store_hit();
    test_store_miss();
    test_conflict();
    go_idle();
    test_reset_mid_refill();
    test_random();
    go_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
Direct-mapped, write-through, no-write-allocate data cache controller between the core's memory stage and main memory.
- Its read data (rdata) feeds the writeback result-select multiplexer as the load-result input.
- It raises stall to freeze the pipeline while a miss refill or a write-through is outstanding.
- Tag/valid/data arrays are flop-based and live inside the block.

Parameters:
LINES, 32, number of cache lines (power of two)
WORDS_PER_LINE, 4, 32-bit words per line (power of two)
ADDR_W, 32, byte address width

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
mem_read  in  1  core load request (memory stage)
mem_write  in  1  core store request (memory stage)
addr  in  ADDR_W  core byte address, word-aligned
wdata  in  32  core store data
rdata  out  32  load data to writeback result mux
stall  out  1  freeze pipeline; core holds addr/wdata/mem_read/mem_write stable while high
mm_req  out  1  main-memory request
mm_we  out  1  1 = word write, 0 = line read
mm_addr  out  ADDR_W  line-aligned for reads; word address for writes
mm_wdata  out  32  write data
mm_ready  in  1  one-cycle completion pulse from main memory
mm_rdata  in  32*WORDS_PER_LINE  full line; word 0 in bits [31:0]; valid when mm_ready

Behaviour:
- Address split:
  - byte offset [1:0], ignored
  - word offset: next log2(WORDS_PER_LINE) bits
  - index: next log2(LINES) bits
  - tag: remainder; default 23 bits
- hit = valid[index] && tag[index] == addr tag. Combinational from current inputs.
- States: IDLE, REFILL, WRITE.
- IDLE:
  - mem_read && hit: rdata = selected word same cycle; stall=0; stay IDLE.
  - mem_read && !hit: stall=1 combinationally; next state REFILL.
  - mem_write: stall=1 combinationally; next state WRITE.
  - mem_write has priority if both requests are asserted.
  - No request: stall=0, rdata=0.
- REFILL:
  - mm_req=1, mm_we=0, mm_addr = addr with word and byte offsets zeroed; stall=1.
  - On mm_ready: write mm_rdata into data[index], set tag[index], set valid[index]; next state IDLE.
  - The following cycle the access hits and completes.
  - Load-miss latency = memory latency + 1 cycle.
- WRITE:
  - mm_req=1, mm_we=1, mm_addr=addr, mm_wdata=wdata; stall=1.
  - On mm_ready: if hit, update the addressed word in the line (tag/valid unchanged); if miss, cache untouched.
  - Next state IDLE. stall deasserts in the mm_ready cycle, so the store retires that cycle.
- mm_req, mm_addr, mm_we and mm_wdata stay stable from entry to a state until mm_ready.
- mm_ready seen in IDLE is ignored.
- Reset values:
  - state=IDLE, all valid bits 0.
  - mm_req=0, mm_we=0, mm_addr=0, mm_wdata=0, stall=0, rdata=0.
  - Data and tag arrays are not reset.
- Reset mid-REFILL/WRITE: abandon the transaction, return to IDLE, invalidate all lines. A late mm_ready is ignored.
- rdata outside an IDLE read hit: 0.

Optional Feature:
Macro: DCACHE_PERF_EN.
- Defined:
  - Adds outputs hit_cnt[31:0] and miss_cnt[31:0], both 0 on reset.
  - hit_cnt increments once per completed load that hits in IDLE without a preceding refill.
  - miss_cnt increments once on each IDLE→REFILL transition.
  - Both counters wrap at 2^32 with no saturation.
- Not defined: ports and counters are absent; all other behaviour is identical.

Decomposition:
Shared package dcache_pkg holds:
- state enum (IDLE=2'd0, REFILL=2'd1, WRITE=2'd2)
- localparams INDEX_W, OFFSET_W and TAG_W derived from LINES, WORDS_PER_LINE and ADDR_W
- an address-field extraction function

One sub-module is natural: dcache_array, holding the tag/valid/data storage.
- Interface: one read port; line write and word write ports; synchronous valid clear on rst.
- The FSM stays in dcache_ctrl.

Test Plan:
- Reset, then mem_read addr=0x0000_0040 with memory returning line {0x44,0x33,0x22,0x11} after 3 cycles → stall high 4 cycles, mm_addr=0x40, then rdata=0x11 with stall=0; miss_cnt=1 with DCACHE_PERF_EN.
- Immediately read 0x0000_0048 → same-cycle hit, rdata=0x33, stall=0, no mm_req.
- Store 0xDEADBEEF to 0x44 (hit) with mm_ready after 2 cycles → mm_we=1, mm_addr=0x44, data stable until ready; subsequent read of 0x44 hits with 0xDEADBEEF.
- Store to 0x1000_0000 (miss) → write-through only; subsequent read of that address misses and refills.
- Conflict: read 0x040, then 0x240 (same index, different tag) → second access refills; re-read of 0x040 misses again.
- Assert rst during REFILL → next cycle IDLE, mm_req=0, stall=0; a stray mm_ready is ignored; re-read of 0x40 misses.
